ghost_mover: RTL

- Parametrised, single-clock ghost movement controller. Generalises the fixed per-colour ghost blocks: one module, instantiated once per ghost with different home, speed and timing parameters.
- Adds the following over the per-colour blocks:
  - mode state machine: HOME, CHASE, FRIGHT, EATEN;
  - fractional speed through a step accumulator;
  - queued turn requests;
  - forced reversal on fright;
  - autonomous return-to-home when eaten.
- Sits between the random/AI direction source and the sprite/collision logic.

---
 rtl/ghost_pkg.sv | 37 +++
 rtl/ghost_step_gen.sv | 32 +++
 rtl/ghost_mover.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ghost_pkg.sv
// ghost_pkg: shared direction/mode types and side-sense helpers for the ghost movers.
package ghost_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      LEFT  = 2'd1,
      DOWN  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      HOME   = 2'd0,
      CHASE  = 2'd1,
      FRIGHT = 2'd2,
      EATEN  = 2'd3
   } mode_t;

   // Opposite heading: the encoding pairs UP/DOWN and LEFT/RIGHT two apart
   function automatic dir_t reverse(input dir_t d);
      return dir_t'(d ^ 2'd2);
   endfunction

   // True when the wall sensor on side d reports nothing (0 = open)
   function automatic logic open_side(input dir_t d, input logic [4:0] mapL,
                                      input logic [4:0] mapR, input logic [4:0] mapB,
                                      input logic [4:0] mapT);
      logic r;
      case (d)
         UP:      r = (mapT == 5'd0);
         LEFT:    r = (mapL == 5'd0);
         DOWN:    r = (mapB == 5'd0);
         default: r = (mapR == 5'd0);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ghost_step_gen.sv
// ghost_step_gen: fractional speed accumulator; emits a 1 px step when the
// per-frame increment carries out of the SPD_W fraction bits.
module ghost_step_gen #(
   parameter int SPD_W = 4
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           frame_tick,
   input  logic [SPD_W:0] spd,
   input  logic           clr,
   output logic           step
);

   logic [SPD_W-1:0] acc;
   logic [SPD_W:0]   sum;

   // spd never exceeds one full step, so the carry bit alone marks a step and
   // the low bits are already the remainder after subtracting it
   assign sum  = {1'b0, acc} + spd;
   assign step = frame_tick & sum[SPD_W];

   // Accumulate the fractional position once per frame
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (frame_tick)
         acc <= sum[SPD_W-1:0];
   end

endmodule

// File: rtl/ghost_mover.sv
// ghost_mover: one ghost's mode FSM, turn queue, speed, tunnel wrap and homing.
module ghost_mover
   import ghost_pkg::*;
#(
   parameter int X_CENTER       = 264,
   parameter int Y_CENTER       = 166,
   parameter int X_MIN          = 7,
   parameter int X_MAX          = 396,
   parameter int Y_MIN          = 7,
   parameter int Y_MAX          = 440,
   parameter int SIZE           = 13,
   parameter int TUN_Y_LO       = 195,
   parameter int TUN_Y_HI       = 223,
   parameter int TUN_L          = 10,
   parameter int TUN_R          = 390,
   parameter int WRAP_L_DEST    = 385,
   parameter int WRAP_R_DEST    = 15,
   parameter int SPD_W          = 4,
   parameter int SPD_CHASE      = 12,
   parameter int SPD_FRIGHT     = 8,
   parameter int SPD_EATEN      = 16,
   parameter int FRIGHT_FRAMES  = 360,
   parameter int RELEASE_FRAMES = 60
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_tick,
   input  logic       restart,
   input  logic [1:0] dir_req,
   input  logic       dir_req_valid,
   input  logic       fright_start,
   input  logic       eaten,
   input  logic [4:0] mapL,
   input  logic [4:0] mapR,
   input  logic [4:0] mapB,
   input  logic [4:0] mapT,
   output logic [9:0] ghostX,
   output logic [9:0] ghostY,
   output logic [9:0] ghostS,
   output logic [1:0] mode,
   output logic [1:0] dir,
   output logic       frightened
);

   localparam logic [SPD_W:0] SPD_C = SPD_CHASE[SPD_W:0];
   localparam logic [SPD_W:0] SPD_F = SPD_FRIGHT[SPD_W:0];
   localparam logic [SPD_W:0] SPD_E = SPD_EATEN[SPD_W:0];

   mode_t          mode_r;
   dir_t           dir_r, pending;
   logic [9:0]     cnt;
   logic [SPD_W:0] spd;
   logic           step, clr_acc, at_home, band_now, band_next;
   dir_t           hx, hy, home_dir, want_dir, mv_dir;
   logic           want_open, dir_open, move_ok, do_move;
   logic [9:0]     mx, my, wx;

   // Border clearance without subtraction; the side borders are not walls
   // inside the tunnel band, otherwise the wrap points could never be reached
   function automatic logic border_ok(input dir_t d, input logic [9:0] x,
                                      input logic [9:0] y, input logic band);
      logic r;
      case (d)
         UP:      r = y > 10'(Y_MIN + SIZE);
         LEFT:    r = band || (x > 10'(X_MIN + SIZE));
         DOWN:    r = ({1'b0, y} + 11'(SIZE)) < 11'(Y_MAX);
         default: r = band || (({1'b0, x} + 11'(SIZE)) < 11'(X_MAX));
      endcase
      return r;
   endfunction

   assign band_now = (ghostY >= 10'(TUN_Y_LO)) && (ghostY <= 10'(TUN_Y_HI));
   assign at_home  = (ghostX == 10'(X_CENTER)) && (ghostY == 10'(Y_CENTER));
   assign clr_acc  = restart || ((mode_r == EATEN) && frame_tick && at_home);

   // Per-mode accumulator increment
   always_comb begin
      case (mode_r)
         CHASE:   spd = SPD_C;
         FRIGHT:  spd = SPD_F;
         EATEN:   spd = SPD_E;
         default: spd = '0;
      endcase
   end

   ghost_step_gen #(.SPD_W(SPD_W)) u_step (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .frame_tick (frame_tick),
      .spd        (spd),
      .clr        (clr_acc),
      .step       (step)
   );

   // Homing direction while EATEN: close the X gap first, fall back to Y
   always_comb begin
      hx = (ghostX < 10'(X_CENTER)) ? RIGHT : LEFT;
      hy = (ghostY < 10'(Y_CENTER)) ? DOWN : UP;
      if ((ghostX != 10'(X_CENTER)) && open_side(hx, mapL, mapR, mapB, mapT) &&
          border_ok(hx, ghostX, ghostY, band_now))
         home_dir = hx;
      else
         home_dir = hy;
   end

   // Pick the heading for this step and form the moved, wrapped position
   always_comb begin
      want_dir  = (mode_r == EATEN) ? home_dir : pending;
      want_open = open_side(want_dir, mapL, mapR, mapB, mapT) &&
                  border_ok(want_dir, ghostX, ghostY, band_now);
      dir_open  = open_side(dir_r, mapL, mapR, mapB, mapT) &&
                  border_ok(dir_r, ghostX, ghostY, band_now);
      mv_dir    = want_open ? want_dir : dir_r;
      // An edge that changes mode through an event does not also move
      case (mode_r)
         CHASE:   move_ok = !fright_start;
         FRIGHT:  move_ok = !eaten;
         EATEN:   move_ok = !at_home;
         default: move_ok = 1'b0;
      endcase
      do_move = step && move_ok && (want_open || dir_open);
      mx = ghostX;
      my = ghostY;
      case (mv_dir)
         UP:      my = ghostY - 10'd1;
         LEFT:    mx = ghostX - 10'd1;
         DOWN:    my = ghostY + 10'd1;
         default: mx = ghostX + 10'd1;
      endcase
      band_next = (my >= 10'(TUN_Y_LO)) && (my <= 10'(TUN_Y_HI));
      wx = mx;
      if (band_next && (mx <= 10'(TUN_L)))
         wx = 10'(WRAP_L_DEST);
      else if (band_next && (mx >= 10'(TUN_R)))
         wx = 10'(WRAP_R_DEST);
   end

   // Position, heading, turn queue and mode FSM
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ghostX     <= 10'(X_CENTER);
         ghostY     <= 10'(Y_CENTER);
         mode_r     <= HOME;
         dir_r      <= LEFT;
         pending    <= LEFT;
         cnt        <= '0;
         frightened <= 1'b0;
      end else if (restart) begin
         ghostX     <= 10'(X_CENTER);
         ghostY     <= 10'(Y_CENTER);
         mode_r     <= HOME;
         dir_r      <= LEFT;
         pending    <= LEFT;
         cnt        <= '0;
         frightened <= 1'b0;
      end else begin
         if (dir_req_valid && (mode_r != EATEN))
            pending <= dir_t'(dir_req);
         if (do_move) begin
            ghostX <= wx;
            ghostY <= my;
            dir_r  <= mv_dir;
         end
         case (mode_r)
            HOME: begin
               if (frame_tick) begin
                  if (cnt == 10'(RELEASE_FRAMES - 1)) begin
                     mode_r <= CHASE;
                     cnt    <= '0;
                  end else begin
                     cnt <= cnt + 10'd1;
                  end
               end
            end
            CHASE: begin
               if (fright_start) begin
                  mode_r     <= FRIGHT;
                  frightened <= 1'b1;
                  cnt        <= '0;
                  dir_r      <= reverse(dir_r);
                  pending    <= reverse(dir_r);
               end
            end
            FRIGHT: begin
               if (eaten) begin
                  mode_r     <= EATEN;
                  frightened <= 1'b0;
               end else if (fright_start) begin
                  cnt <= '0;
               end else if (frame_tick) begin
                  if (cnt == 10'(FRIGHT_FRAMES - 1)) begin
                     mode_r     <= CHASE;
                     frightened <= 1'b0;
                     cnt        <= '0;
                  end else begin
                     cnt <= cnt + 10'd1;
                  end
               end
            end
            default: begin
               if (frame_tick) begin
                  pending <= home_dir;
                  if (at_home) begin
                     mode_r <= HOME;
                     cnt    <= '0;
                  end
               end
            end
         endcase
      end
   end

   assign mode   = mode_r;
   assign dir    = dir_r;
   assign ghostS = 10'(SIZE);

endmodule
